// File: rtl/decoder_nto2n_scan_if.sv
// Select/decode bundle for decoder_nto2n_scan: the controller side drives
// en/mode/sel, and the decoder side returns dout/idx/valid/wrap.
interface decoder_nto2n_scan_if #(
  parameter int N = 3
) ();
  logic                en;
  logic                mode;
  logic [N-1:0]        sel;
  logic [(1<<N)-1:0]   dout;
  logic [N-1:0]        idx;
  logic                valid;
  logic                wrap;

  modport master (output en, mode, sel, input dout, idx, valid, wrap);
  modport slave  (input en, mode, sel, output dout, idx, valid, wrap);
endinterface

// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N one-hot decoder with an auto-scan sequencer that walks
// the outputs, holding each index for DWELL cycles; polarity is set by ACTIVE_LOW.
module decoder_nto2n_scan #(
  parameter int N          = 3,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  decoder_nto2n_scan_if.slave   bus
);
  localparam int W  = 1 << N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [W-1:0]  OFF      = {W{ACTIVE_LOW}};
  localparam logic [N-1:0]  IDX_MAX  = '1;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t         st_q, st_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           wrap_q, wrap_d;

  // Polarity is folded in here so dout leaves straight from the register.
  function automatic logic [W-1:0] decode(input logic [N-1:0] k);
    logic [W-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v ^ OFF;
  endfunction

  always_comb begin
    st_d    = IDLE;
    idx_d   = idx_q;
    cnt_d   = '0;
    dout_d  = OFF;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (bus.en && !bus.mode) begin
      st_d    = DIRECT;
      idx_d   = bus.sel;
      dout_d  = decode(bus.sel);
      valid_d = 1'b1;
    end else if (bus.en) begin
      st_d    = SCAN;
      valid_d = 1'b1;
      if (st_q != SCAN) begin
        idx_d  = bus.sel;
        dout_d = decode(bus.sel);
      end else if (cnt_q == CNT_LAST) begin
        idx_d  = idx_q + N'(1);
        dout_d = decode(idx_q + N'(1));
        wrap_d = (idx_q == IDX_MAX);
      end else begin
        cnt_d  = cnt_q + CW'(1);
        dout_d = dout_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= OFF;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Bench for decoder_nto2n_scan: an active-high and an active-low instance
// (N=3, DWELL=2) receive identical stimulus and are checked against expectations.
module tb_decoder_nto2n_scan;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_nto2n_scan_if #(.N(3)) bus_h ();
  decoder_nto2n_scan_if #(.N(3)) bus_l ();

  decoder_nto2n_scan #(.N(3), .DWELL(2), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .bus(bus_h));
  decoder_nto2n_scan #(.N(3), .DWELL(2), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .bus(bus_l));

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] dout;
    logic [2:0] idx;
    logic       valid;
    logic       wrap;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[8];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected record is queued when its inputs are driven and retired one edge later.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst;
    bus_h.en = v.en;  bus_h.mode = v.mode;  bus_h.sel = v.sel;
    bus_l.en = v.en;  bus_l.mode = v.mode;  bus_l.sel = v.sel;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.name, ".dout_h"},  bus_h.dout,         e.dout);
    check({e.name, ".dout_l"},  bus_l.dout,         ~e.dout);
    check({e.name, ".idx_h"},   {5'b0, bus_h.idx},  {5'b0, e.idx});
    check({e.name, ".idx_l"},   {5'b0, bus_l.idx},  {5'b0, e.idx});
    check({e.name, ".valid_h"}, {7'b0, bus_h.valid}, {7'b0, e.valid});
    check({e.name, ".valid_l"}, {7'b0, bus_l.valid}, {7'b0, e.valid});
    check({e.name, ".wrap_h"},  {7'b0, bus_h.wrap},  {7'b0, e.wrap});
    check({e.name, ".wrap_l"},  {7'b0, bus_l.wrap},  {7'b0, e.wrap});
  endtask

  function automatic vec_t mk(input string name, input logic r, input logic en,
                              input logic mode, input logic [2:0] sel,
                              input logic [7:0] dout, input logic [2:0] idx,
                              input logic valid, input logic wrap);
    vec_t v;
    v.name = name; v.rst = r; v.en = en; v.mode = mode; v.sel = sel;
    v.dout = dout; v.idx = idx; v.valid = valid; v.wrap = wrap;
    return v;
  endfunction

  initial begin
    #2000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      logic [7:0] one;
      one = 8'h01;
      tbl[i] = mk($sformatf("direct%0d", i), 1'b0, 1'b1, 1'b0, 3'(i),
                  one << i, 3'(i), 1'b1, 1'b0);
    end

    rst = 1'b1;
    bus_h.en = 1'b0; bus_h.mode = 1'b0; bus_h.sel = '0;
    bus_l.en = 1'b0; bus_l.mode = 1'b0; bus_l.sel = '0;

    step(mk("reset0", 1, 0, 0, 3'd0, 8'h00, 3'd0, 0, 0));
    step(mk("reset1", 1, 0, 0, 3'd0, 8'h00, 3'd0, 0, 0));
    step(mk("idle",   0, 0, 0, 3'd0, 8'h00, 3'd0, 0, 0));

    for (int i = 0; i < 8; i++) step(tbl[i]);

    // Scan from 6 through the rollover; sel changes after entry must be ignored.
    step(mk("scan6a", 0, 1, 1, 3'd6, 8'h40, 3'd6, 1, 0));
    step(mk("scan6b", 0, 1, 1, 3'd0, 8'h40, 3'd6, 1, 0));
    step(mk("scan7a", 0, 1, 1, 3'd2, 8'h80, 3'd7, 1, 0));
    step(mk("scan7b", 0, 1, 1, 3'd2, 8'h80, 3'd7, 1, 0));
    step(mk("scan0a", 0, 1, 1, 3'd2, 8'h01, 3'd0, 1, 1));
    step(mk("scan0b", 0, 1, 1, 3'd2, 8'h01, 3'd0, 1, 0));
    step(mk("scan1a", 0, 1, 1, 3'd2, 8'h02, 3'd1, 1, 0));

    // Disable mid-dwell, then restart from sel=3 with a fresh dwell count.
    step(mk("dis",    0, 0, 1, 3'd2, 8'h00, 3'd1, 0, 0));
    step(mk("rest3a", 0, 1, 1, 3'd3, 8'h08, 3'd3, 1, 0));
    step(mk("rest3b", 0, 1, 1, 3'd3, 8'h08, 3'd3, 1, 0));
    step(mk("rest4a", 0, 1, 1, 3'd3, 8'h10, 3'd4, 1, 0));

    // Scan to direct mid-dwell, then re-enter scan at 7 to see 7 -> 0.
    step(mk("todir5", 0, 1, 0, 3'd5, 8'h20, 3'd5, 1, 0));
    step(mk("scan7c", 0, 1, 1, 3'd7, 8'h80, 3'd7, 1, 0));
    step(mk("scan7d", 0, 1, 1, 3'd7, 8'h80, 3'd7, 1, 0));
    step(mk("wrap0",  0, 1, 1, 3'd7, 8'h01, 3'd0, 1, 1));

    step(mk("rstscan", 1, 1, 1, 3'd4, 8'h00, 3'd0, 0, 0));

    // Scan entry at index 0 must not pulse wrap.
    step(mk("ent0a",  0, 1, 1, 3'd0, 8'h01, 3'd0, 1, 0));
    step(mk("ent0b",  0, 1, 1, 3'd0, 8'h01, 3'd0, 1, 0));
    step(mk("ent0c",  0, 1, 1, 3'd0, 8'h02, 3'd1, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
